// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides the system clock down to a pixel strobe
// and produces pixel/line counters, sync pulses, visible-area flag and frame markers.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             pix_stb;
    logic             h_wrap;
    logic             v_wrap;

    // Wrap conditions are qualified by the pixel strobe, so en=0 freezes everything.
    always_comb begin
        pix_stb = en && (div_q == DIV_LAST);
        h_wrap  = pix_stb && (h_cnt_q == H_LAST);
        v_wrap  = h_wrap && (v_cnt_q == V_LAST);
    end

    always_comb begin
        div_d         = div_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        line_start_d  = h_wrap;
        frame_start_d = v_wrap;

        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (pix_stb) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        end
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
        if (v_wrap) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Pulses are suppressed while paused so a stall never shows a marker.
    always_comb begin
        pclk_en     = pix_stb;
        h_cnt       = h_cnt_q;
        v_cnt       = v_cnt_q;
        frame_count = frame_count_q;
        line_start  = line_start_q && en;
        frame_start = frame_start_q && en;
        valid       = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so that more than 256 frames
// fit in a short run; expectations come from an enabled-cycle arithmetic model.
module tb_vga_timing_gen;

    localparam int CD = 3;
    localparam int HD = 6, HF = 1, HS = 2, HB = 1;
    localparam int VD = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pclk_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    vga_timing_gen #(
        .CLK_DIV(CD),
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pclk_en(pclk_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .valid(valid), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model state: enabled clocks since reset, plus pulses armed by the last edge.
    int e    = 0;
    bit ls_m = 1'b0;
    bit fs_m = 1'b0;

    function automatic int pix();
        return e / CD;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int p, h, v;
        p = pix();
        h = p % HT;
        v = (p / HT) % VT;
        chk("pclk_en", int'(pclk_en), int'(en && (e % CD == CD - 1)));
        chk("h_cnt", int'(h_cnt), h);
        chk("v_cnt", int'(v_cnt), v);
        chk("frame_count", int'(frame_count), (p / FR) % 256);
        chk("valid", int'(valid), int'(h < HD && v < VD));
        chk("hsync", int'(hsync), int'(!(h >= HD + HF && h < HD + HF + HS)));
        chk("vsync", int'(vsync), int'(!(v >= VD + VF && v < VD + VF + VS)));
        chk("line_start", int'(line_start), int'(ls_m && en));
        chk("frame_start", int'(frame_start), int'(fs_m && en));
    endtask

    // One clock: drive at the falling edge, check just after, advance model at the rising edge.
    task automatic step(input bit en_v, input bit rst_v);
        @(negedge clk);
        en  = en_v;
        rst = rst_v;
        #1;
        if (rst_v) begin
            e    = 0;
            ls_m = 1'b0;
            fs_m = 1'b0;
        end
        check_all();
        @(posedge clk);
        if (!rst_v) begin
            ls_m = 1'b0;
            fs_m = 1'b0;
            if (en_v) begin
                if (e % CD == CD - 1) begin
                    ls_m = ((pix() + 1) % HT == 0);
                    fs_m = ((pix() + 1) % FR == 0);
                end
                e++;
            end
        end
    endtask

    task automatic run_to(input int target_mod, input string tag);
        int n;
        n = 0;
        while ((pix() % FR != target_mod) && n < 4 * CD * FR) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk(tag, int'(n < 4 * CD * FR), 1);
    endtask

    initial begin
        int n;
        // Reset held, with en low then high.
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);

        // Release: first strobe on clock index CD-1, then every CD clocks.
        repeat (20) step(1'b1, 1'b0);

        // Pause at the last pixel of the frame, then resume through the wrap.
        for (int k = 0; k < 2; k++) begin
            run_to(FR - 1, "reach_last_pixel");
            repeat (50) step(1'b0, 1'b0);
            repeat (3 * CD * HT) step(1'b1, 1'b0);
        end

        // Randomised enable across more than 256 frames to cover frame_count wrap.
        n = 0;
        while (pix() < 258 * FR && n < 80000) begin
            step(($urandom_range(0, 9) != 0), 1'b0);
            n++;
        end
        chk("random_run_budget", int'(n < 80000), 1);

        // Asynchronous reset in the middle of the sync pulses, between clock edges.
        run_to((VD + VF) * HT + HD + HF + 1, "reach_mid_frame");
        #2;
        rst = 1'b1;
        #1;
        e    = 0;
        ls_m = 1'b0;
        fs_m = 1'b0;
        check_all();
        repeat (3) step(1'b1, 1'b1);
        repeat (3 * CD * HT + 7) step(1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
